// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares one block-level data memory between the instruction cache
//   (read-only) and the data cache (read/write). Misses are served one at a
//   time with round-robin fairness, and a watchdog aborts a memory
//   transaction that never completes.
//
// Ports
//   clk_i, rst_ni           : clock (rising edge), asynchronous active-low reset
//   i_read_i, i_address_i   : icache block read request / block address
//   i_readdata_o            : block returned to icache
//   i_busywait_o            : icache stall
//   d_read_i, d_write_i     : dcache block read / write-back request
//   d_address_i             : dcache block address
//   d_writedata_i           : dcache write-back block
//   d_readdata_o            : block returned to dcache
//   d_busywait_o            : dcache stall
//   mem_read_o, mem_write_o : registered memory strobes
//   mem_address_o           : registered block address
//   mem_writedata_o         : registered write block
//   mem_readdata_i          : memory read block
//   mem_busywait_i          : memory busy
//   grant_o                 : one-hot {dcache, icache} owner, 00 when idle
//   timeout_err_o           : sticky watchdog flag
module mem_arbiter #(
   parameter int unsigned ADDR_WIDTH     = 28,
   parameter int unsigned BLOCK_WIDTH    = 128,
   parameter int unsigned TIMEOUT_CYCLES = 255,
   parameter bit          FIRST_PRIORITY = 1'b1
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   i_read_i,
   input  logic [ADDR_WIDTH-1:0]  i_address_i,
   output logic [BLOCK_WIDTH-1:0] i_readdata_o,
   output logic                   i_busywait_o,
   input  logic                   d_read_i,
   input  logic                   d_write_i,
   input  logic [ADDR_WIDTH-1:0]  d_address_i,
   input  logic [BLOCK_WIDTH-1:0] d_writedata_i,
   output logic [BLOCK_WIDTH-1:0] d_readdata_o,
   output logic                   d_busywait_o,
   output logic                   mem_read_o,
   output logic                   mem_write_o,
   output logic [ADDR_WIDTH-1:0]  mem_address_o,
   output logic [BLOCK_WIDTH-1:0] mem_writedata_o,
   input  logic [BLOCK_WIDTH-1:0] mem_readdata_i,
   input  logic                   mem_busywait_i,
   output logic [1:0]             grant_o,
   output logic                   timeout_err_o
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_SERVE_I = 2'd1,
      ST_SERVE_D = 2'd2
   } state_t;

   // Watchdog value at which the current edge is the last one allowed.
   localparam logic [7:0] WD_LAST = 8'(TIMEOUT_CYCLES - 1);

   state_t                 state_q;
   logic                   seen_busy_q;
   logic [7:0]             watchdog_q;
   logic                   last_grant_q;   // 1 = dcache was granted last
   logic [1:0]             grant_q;
   logic                   mem_read_q;
   logic                   mem_write_q;
   logic [ADDR_WIDTH-1:0]  mem_address_q;
   logic [BLOCK_WIDTH-1:0] mem_writedata_q;
   logic [BLOCK_WIDTH-1:0] hold_i_q;
   logic [BLOCK_WIDTH-1:0] hold_d_q;
   logic                   timeout_err_q;

   logic serving;
   logic done;
   logic abort;
   logic finish;
   logic i_pend;
   logic d_pend;
   logic pick_d;

   assign serving = (state_q != ST_IDLE);
   // Memory must have been seen busy before a low busywait means completion;
   // otherwise the cycle right after the strobe would look like a finish.
   assign done    = serving & seen_busy_q & ~mem_busywait_i;
   assign abort   = serving & (watchdog_q == WD_LAST) & ~done;
   assign finish  = done | abort;

   assign i_pend  = i_read_i;
   assign d_pend  = d_read_i | d_write_i;
   // On contention the requester that was not granted last wins.
   assign pick_d  = d_pend & (~i_pend | ~last_grant_q);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q         <= ST_IDLE;
         seen_busy_q     <= 1'b0;
         watchdog_q      <= '0;
         last_grant_q    <= ~FIRST_PRIORITY;
         grant_q         <= 2'b00;
         mem_read_q      <= 1'b0;
         mem_write_q     <= 1'b0;
         mem_address_q   <= '0;
         mem_writedata_q <= '0;
         hold_i_q        <= '0;
         hold_d_q        <= '0;
         timeout_err_q   <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (pick_d) begin
                  // A simultaneous read is dropped in favour of the write-back.
                  state_q         <= ST_SERVE_D;
                  grant_q         <= 2'b10;
                  last_grant_q    <= 1'b1;
                  mem_read_q      <= ~d_write_i;
                  mem_write_q     <= d_write_i;
                  mem_address_q   <= d_address_i;
                  mem_writedata_q <= d_writedata_i;
               end else if (i_pend) begin
                  state_q         <= ST_SERVE_I;
                  grant_q         <= 2'b01;
                  last_grant_q    <= 1'b0;
                  mem_read_q      <= 1'b1;
                  mem_write_q     <= 1'b0;
                  mem_address_q   <= i_address_i;
               end
            end
            ST_SERVE_I, ST_SERVE_D: begin
               if (finish) begin
                  state_q     <= ST_IDLE;
                  grant_q     <= 2'b00;
                  mem_read_q  <= 1'b0;
                  mem_write_q <= 1'b0;
                  seen_busy_q <= 1'b0;
                  watchdog_q  <= '0;
                  if (state_q == ST_SERVE_I) begin
                     hold_i_q <= done ? mem_readdata_i : '0;
                  end else begin
                     hold_d_q <= done ? mem_readdata_i : '0;
                  end
                  if (abort) begin
                     timeout_err_q <= 1'b1;
                  end
               end else begin
                  watchdog_q <= watchdog_q + 8'd1;
                  if (mem_busywait_i) begin
                     seen_busy_q <= 1'b1;
                  end
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   // Owner sees memory data directly so it is valid in the finishing cycle.
   assign i_readdata_o    = grant_q[0] ? mem_readdata_i : hold_i_q;
   assign d_readdata_o    = grant_q[1] ? mem_readdata_i : hold_d_q;
   assign i_busywait_o    = i_pend & ~(grant_q[0] & finish);
   assign d_busywait_o    = d_pend & ~(grant_q[1] & finish);

   assign mem_read_o      = mem_read_q;
   assign mem_write_o     = mem_write_q;
   assign mem_address_o   = mem_address_q;
   assign mem_writedata_o = mem_writedata_q;
   assign grant_o         = grant_q;
   assign timeout_err_o   = timeout_err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: directed scenarios driven from one initial block,
// a behavioural memory, a reference model compared on every falling edge, and
// literal expectations for each scenario.
module tb_mem_arbiter;
   localparam int AW      = 28;
   localparam int BW      = 128;
   localparam int T       = 8;
   localparam int MEM_LAT = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic          i_read = 1'b0;
   logic [AW-1:0] i_address = '0;
   logic [BW-1:0] i_readdata;
   logic          i_busywait;
   logic          d_read = 1'b0;
   logic          d_write = 1'b0;
   logic [AW-1:0] d_address = '0;
   logic [BW-1:0] d_writedata = '0;
   logic [BW-1:0] d_readdata;
   logic          d_busywait;
   logic          mem_read;
   logic          mem_write;
   logic [AW-1:0] mem_address;
   logic [BW-1:0] mem_writedata;
   logic [BW-1:0] mem_readdata = '0;
   logic          mem_busywait;
   logic [1:0]    grant;
   logic          timeout_err;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mem_arbiter #(
      .ADDR_WIDTH(AW), .BLOCK_WIDTH(BW), .TIMEOUT_CYCLES(T), .FIRST_PRIORITY(1'b1)
   ) dut (
      .clk_i(clk), .rst_ni(rst_n),
      .i_read_i(i_read), .i_address_i(i_address), .i_readdata_o(i_readdata),
      .i_busywait_o(i_busywait),
      .d_read_i(d_read), .d_write_i(d_write), .d_address_i(d_address),
      .d_writedata_i(d_writedata), .d_readdata_o(d_readdata), .d_busywait_o(d_busywait),
      .mem_read_o(mem_read), .mem_write_o(mem_write), .mem_address_o(mem_address),
      .mem_writedata_o(mem_writedata), .mem_readdata_i(mem_readdata),
      .mem_busywait_i(mem_busywait), .grant_o(grant), .timeout_err_o(timeout_err)
   );

   // Memory: notices a strobe one edge late, then stays busy MEM_LAT cycles.
   logic mem_busy_r = 1'b0;
   logic mem_stuck  = 1'b0;
   int   mem_phase  = 0;
   int   mem_cnt    = 0;
   always @(posedge clk) begin
      if (!(mem_read || mem_write)) begin
         mem_phase  <= 0;
         mem_busy_r <= 1'b0;
      end else if (mem_phase == 0) begin
         mem_busy_r <= 1'b1;
         mem_cnt    <= MEM_LAT - 1;
         mem_phase  <= 1;
      end else if (mem_phase == 1) begin
         if (mem_cnt == 0) begin
            mem_busy_r <= 1'b0;
            mem_phase  <= 2;
         end else begin
            mem_cnt <= mem_cnt - 1;
         end
      end
   end
   assign mem_busywait = mem_stuck | mem_busy_r;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Reference model: who owns memory, how long it has been served, whether
   // memory has been seen busy, what each cache last received.
   int            m_owner;    // 0 none, 1 icache, 2 dcache
   bit            m_seen;
   int            m_age;      // edges spent in service so far
   bit            m_last_d;
   bit            m_wr;
   logic [AW-1:0] m_addr;
   logic [BW-1:0] m_wdata;
   logic [BW-1:0] m_hold_i;
   logic [BW-1:0] m_hold_d;
   bit            m_err;

   function automatic bit m_done_f();
      return (m_owner != 0) && m_seen && !mem_busywait;
   endfunction
   function automatic bit m_abort_f();
      return (m_owner != 0) && (m_age == T - 1) && !m_done_f();
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_owner <= 0; m_seen <= 1'b0; m_age <= 0; m_last_d <= 1'b0;
         m_wr <= 1'b0; m_hold_i <= '0; m_hold_d <= '0; m_err <= 1'b0;
      end else if (m_owner == 0) begin
         if ((d_read || d_write) && (!i_read || !m_last_d)) begin
            m_owner <= 2; m_last_d <= 1'b1; m_wr <= d_write;
            m_addr <= d_address; m_wdata <= d_writedata;
         end else if (i_read) begin
            m_owner <= 1; m_last_d <= 1'b0; m_wr <= 1'b0; m_addr <= i_address;
         end
      end else if (m_done_f() || m_abort_f()) begin
         if (m_owner == 1) m_hold_i <= m_done_f() ? mem_readdata : '0;
         else              m_hold_d <= m_done_f() ? mem_readdata : '0;
         if (m_abort_f()) m_err <= 1'b1;
         m_owner <= 0; m_seen <= 1'b0; m_age <= 0;
      end else begin
         m_age <= m_age + 1;
         if (mem_busywait) m_seen <= 1'b1;
      end
   end

   bit c_fin_i, c_fin_d;
   always @(negedge clk) begin
      if (rst_n) begin
         c_fin_i = (m_owner == 1) && (m_done_f() || m_abort_f());
         c_fin_d = (m_owner == 2) && (m_done_f() || m_abort_f());
         check("cmp_grant", 128'(grant), 128'((m_owner == 1) ? 2'b01 : (m_owner == 2) ? 2'b10 : 2'b00));
         check("cmp_mem_read", 128'(mem_read), 128'((m_owner != 0) && !m_wr));
         check("cmp_mem_write", 128'(mem_write), 128'((m_owner != 0) && m_wr));
         if (m_owner != 0) check("cmp_mem_address", 128'(mem_address), 128'(m_addr));
         if (m_owner != 0 && m_wr) check("cmp_mem_writedata", mem_writedata, m_wdata);
         check("cmp_i_readdata", i_readdata, (m_owner == 1) ? mem_readdata : m_hold_i);
         check("cmp_d_readdata", d_readdata, (m_owner == 2) ? mem_readdata : m_hold_d);
         check("cmp_i_busywait", 128'(i_busywait), 128'(i_read && !c_fin_i));
         check("cmp_d_busywait", 128'(d_busywait), 128'((d_read || d_write) && !c_fin_d));
         check("cmp_timeout_err", 128'(timeout_err), 128'(m_err));
      end
   end

   // Grant log: one entry per new grant.
   logic [1:0] glog[$];
   logic [1:0] gprev = 2'b00;
   always @(negedge clk) begin
      if (grant != 2'b00 && gprev == 2'b00) glog.push_back(grant);
      gprev <= grant;
   end

   int i_served = 0, d_served = 0, i_auto = 0, d_auto = 0;

   // Cache behaviour: drop a request after seeing busywait low; optionally
   // re-request one cycle later.
   task automatic apply_drops(input bit ib, input bit db);
      if (i_read && !ib) begin
         i_read = 1'b0; i_served++;
      end else if (!i_read && i_auto > 0) begin
         i_read = 1'b1; i_auto--;
      end
      if ((d_read || d_write) && !db) begin
         d_read = 1'b0; d_write = 1'b0; d_served++;
      end else if (!(d_read || d_write) && d_auto > 0) begin
         d_read = 1'b1; d_auto--;
      end
   endtask

   task automatic tick();
      bit ib, db;
      @(negedge clk);
      ib = i_busywait; db = d_busywait;
      @(posedge clk); #1;
      apply_drops(ib, db);
   endtask

   // Runs until the chosen cache sees busywait low; captures what it saw then.
   task automatic wait_done(input bit is_d, output int strobe_n, output int idle_n,
                            output bit other_ok, output logic [1:0] g,
                            output logic [BW-1:0] rd, output logic [AW-1:0] a,
                            output logic [BW-1:0] wd, output logic rs,
                            output logic ws, output bit ok);
      bit ib, db;
      strobe_n = 0; idle_n = 0; other_ok = 1'b1; ok = 1'b0;
      g = '0; rd = '0; a = '0; wd = '0; rs = 1'b0; ws = 1'b0;
      for (int k = 0; k < 60 && !ok; k++) begin
         @(negedge clk);
         ib = i_busywait; db = d_busywait;
         if (grant == (is_d ? 2'b10 : 2'b01) && (mem_read || mem_write)) strobe_n++;
         if (grant == 2'b00 && strobe_n == 0) idle_n++;
         if (is_d && i_read && !ib) other_ok = 1'b0;
         if (!is_d && (d_read || d_write) && !db) other_ok = 1'b0;
         if (is_d ? ((d_read || d_write) && !db) : (i_read && !ib)) begin
            ok = 1'b1; g = grant; rd = is_d ? d_readdata : i_readdata;
            a = mem_address; wd = mem_writedata; rs = mem_read; ws = mem_write;
         end
         @(posedge clk); #1;
         apply_drops(ib, db);
      end
      if (!ok) begin
         checks++; errors++;
         $display("FAIL wait_done_timeout: requester %0d never released, expected completion", is_d);
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      i_read = 1'b0; d_read = 1'b0; d_write = 1'b0; i_auto = 0; d_auto = 0;
      @(posedge clk); #2;
      check("rst_grant", 128'(grant), 128'(2'b00));
      check("rst_mem_read", 128'(mem_read), 128'(1'b0));
      check("rst_mem_write", 128'(mem_write), 128'(1'b0));
      check("rst_timeout_err", 128'(timeout_err), 128'(1'b0));
      check("rst_i_readdata", i_readdata, 128'(0));
      @(posedge clk); #2;
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   int            sn, idn;
   bit            oo, ok;
   logic [1:0]    g;
   logic [BW-1:0] rd, wd;
   logic [AW-1:0] a;
   logic          rs, ws;
   logic [1:0]    exp_seq[6];

   initial begin
      do_reset();

      // Single icache read
      mem_readdata = {4{32'hA5A5A5A5}};
      i_address = 28'h0000010; i_read = 1'b1;
      wait_done(1'b0, sn, idn, oo, g, rd, a, wd, rs, ws, ok);
      if (ok) begin
         check("t1_grant", 128'(g), 128'(2'b01));
         check("t1_readdata", rd, {4{32'hA5A5A5A5}});
         check("t1_strobe_cycles", 128'(sn), 128'(6));
         check("t1_address", 128'(a), 128'(28'h0000010));
         check("t1_mem_read", 128'(rs), 128'(1'b1));
      end
      @(negedge clk);
      check("t1_grant_idle", 128'(grant), 128'(2'b00));
      check("t1_held_readdata", i_readdata, {4{32'hA5A5A5A5}});
      @(posedge clk); #1;

      // Contention straight after reset: dcache first, then icache after one idle cycle
      do_reset();
      mem_readdata = {4{32'hC3C3C3C3}};
      i_address = 28'h0000020; d_address = 28'h0000030;
      i_read = 1'b1; d_read = 1'b1;
      wait_done(1'b1, sn, idn, oo, g, rd, a, wd, rs, ws, ok);
      if (ok) begin
         check("t2_first_grant", 128'(g), 128'(2'b10));
         check("t2_icache_stalled", 128'(oo), 128'(1'b1));
         check("t2_d_readdata", rd, {4{32'hC3C3C3C3}});
      end
      wait_done(1'b0, sn, idn, oo, g, rd, a, wd, rs, ws, ok);
      if (ok) begin
         check("t2_second_grant", 128'(g), 128'(2'b01));
         check("t2_idle_gap", 128'(idn), 128'(1));
         check("t2_i_address", 128'(a), 128'(28'h0000020));
      end

      // Fairness over six back-to-back transactions
      i_served = 0; d_served = 0; glog.delete();
      i_auto = 2; d_auto = 2; i_read = 1'b1; d_read = 1'b1;
      for (int k = 0; k < 300 && !(i_served >= 3 && d_served >= 3); k++) tick();
      exp_seq = '{2'b10, 2'b01, 2'b10, 2'b01, 2'b10, 2'b01};
      check("t3_grant_count", 128'(glog.size()), 128'(6));
      for (int k = 0; k < 6 && k < glog.size(); k++)
         check($sformatf("t3_grant_%0d", k), 128'(glog[k]), 128'(exp_seq[k]));

      // Write-back with read also raised; write data changes mid-service
      mem_readdata = {4{32'h0F0F0F0F}};
      d_address = 28'h00000ff; d_writedata = {4{32'h12345678}};
      d_read = 1'b1; d_write = 1'b1;
      tick(); tick();
      d_writedata = {4{32'hDEADBEEF}};
      wait_done(1'b1, sn, idn, oo, g, rd, a, wd, rs, ws, ok);
      if (ok) begin
         check("t4_grant", 128'(g), 128'(2'b10));
         check("t4_address", 128'(a), 128'(28'h00000ff));
         check("t4_writedata", wd, {4{32'h12345678}});
         check("t4_mem_write", 128'(ws), 128'(1'b1));
         check("t4_mem_read", 128'(rs), 128'(1'b0));
      end

      // Watchdog: memory never finishes
      mem_stuck = 1'b1; mem_readdata = {4{32'hFFFFFFFF}};
      d_address = 28'h0000040; d_read = 1'b1;
      wait_done(1'b1, sn, idn, oo, g, rd, a, wd, rs, ws, ok);
      mem_stuck = 1'b0;
      if (ok) begin
         check("t5_abort_cycle", 128'(sn), 128'(T));
         check("t5_grant", 128'(g), 128'(2'b10));
      end
      @(negedge clk);
      check("t5_d_readdata_zero", d_readdata, 128'(0));
      check("t5_timeout_err", 128'(timeout_err), 128'(1'b1));
      @(posedge clk); #1;
      mem_readdata = {4{32'h5A5A5A5A}};
      i_address = 28'h0000044; i_read = 1'b1;
      wait_done(1'b0, sn, idn, oo, g, rd, a, wd, rs, ws, ok);
      if (ok) check("t5_readdata_after", rd, {4{32'h5A5A5A5A}});
      @(negedge clk);
      check("t5_err_sticky", 128'(timeout_err), 128'(1'b1));
      @(posedge clk); #1;

      // Asynchronous reset in the middle of an icache service
      i_address = 28'h0000050; i_read = 1'b1;
      tick(); tick(); tick();
      #2 rst_n = 1'b0;
      #1;
      check("t6_mem_read", 128'(mem_read), 128'(1'b0));
      check("t6_grant", 128'(grant), 128'(2'b00));
      check("t6_timeout_err", 128'(timeout_err), 128'(1'b0));
      i_read = 1'b0;
      @(posedge clk); #2 rst_n = 1'b1;
      @(posedge clk); #1;
      i_read = 1'b1; d_read = 1'b1;
      wait_done(1'b1, sn, idn, oo, g, rd, a, wd, rs, ws, ok);
      if (ok) check("t6_first_grant", 128'(g), 128'(2'b10));
      wait_done(1'b0, sn, idn, oo, g, rd, a, wd, rs, ws, ok);
      if (ok) check("t6_second_grant", 128'(g), 128'(2'b01));

      tick(); tick(); tick();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL global_timeout: simulation did not finish, expected completion");
      $fatal(1);
   end

   // One line per transaction.
   always @(negedge clk) begin
      if (rst_n && (mem_read || mem_write) && (i_busywait == 1'b0 && grant[0] && i_read ||
                                               d_busywait == 1'b0 && grant[1] && (d_read || d_write)))
         $display("txn t=%0t grant=%b %s addr=%0h err=%0b", $time, grant,
                  mem_write ? "WR" : "RD", mem_address, timeout_err);
   end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single block-level data_memory between the instruction cache (read-only) and the data cache (read/write).
- Sits between both cache miss interfaces and data_memory.
- Presents each cache with the same read/write/busywait/block-data handshake that data_memory presents.
- Serialises misses with round-robin fairness; a watchdog aborts a hung memory transaction.

Parameters:
ADDR_WIDTH, 28, block address width
BLOCK_WIDTH, 128, block data width
TIMEOUT_CYCLES, 255, max cycles in a serve state before abort (1..255)
FIRST_PRIORITY, 1, requester preferred on first contention after reset (1 = dcache, 0 = icache)

Ports:
CLK  in  1  clock, rising edge
RESET  in  1  asynchronous, active-low reset
I_READ  in  1  icache block read request
I_ADDRESS  in  ADDR_WIDTH  icache block address
I_READDATA  out  BLOCK_WIDTH  block returned to icache
I_BUSYWAIT  out  1  icache stall
D_READ  in  1  dcache block read request
D_WRITE  in  1  dcache block write-back request
D_ADDRESS  in  ADDR_WIDTH  dcache block address
D_WRITEDATA  in  BLOCK_WIDTH  dcache write-back block
D_READDATA  out  BLOCK_WIDTH  block returned to dcache
D_BUSYWAIT  out  1  dcache stall
MEM_READ  out  1  data_memory read strobe, registered
MEM_WRITE  out  1  data_memory write strobe, registered
MEM_ADDRESS  out  ADDR_WIDTH  registered block address
MEM_WRITEDATA  out  BLOCK_WIDTH  registered write block
MEM_READDATA  in  BLOCK_WIDTH  data_memory read block
MEM_BUSYWAIT  in  1  data_memory busy
GRANT  out  2  one-hot {dcache, icache} owner; 00 when idle
TIMEOUT_ERR  out  1  sticky watchdog flag

Behaviour:
- Reset (RESET low, asynchronous):
  - state = IDLE; MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITEDATA, GRANT, TIMEOUT_ERR, read holding registers = 0.
  - seen_busy = 0, watchdog = 0, last_grant = ~FIRST_PRIORITY.
  - Reset mid-transaction discards the transaction with no completion.
- States: IDLE, SERVE_I, SERVE_D.
- IDLE:
  - At each edge, a requester is pending if its request is high (dcache: D_READ|D_WRITE).
  - If only one is pending, grant it. If both are pending, grant the one not in last_grant.
  - On grant: latch address, op and write data into MEM_*; set GRANT; update last_grant; enter SERVE_x.
  - No request: remain in IDLE.
- SERVE_x:
  - MEM_* are held stable.
  - seen_busy is set on the first edge at which MEM_BUSYWAIT = 1.
  - done = seen_busy & ~MEM_BUSYWAIT (combinational).
  - watchdog increments each cycle; abort = (watchdog == TIMEOUT_CYCLES-1) & ~done.
- Completion (done or abort edge):
  - MEM_READ/MEM_WRITE ← 0; GRANT ← 00; seen_busy, watchdog ← 0; state ← IDLE.
  - Owner's holding register ← MEM_READDATA on done, 0 on abort.
  - Abort also sets TIMEOUT_ERR, which stays set until reset.
- Read-data path: while granted, X_READDATA = MEM_READDATA (combinational). Otherwise X_READDATA = its holding register. Data is therefore valid in the done cycle.
- Busywait:
  - I_BUSYWAIT = I_READ & ~(GRANT[0] & (done|abort)).
  - D_BUSYWAIT = (D_READ|D_WRITE) & ~(GRANT[1] & (done|abort)).
  - A cache waiting for, or holding, the grant stays stalled.
- Turnaround: at least one IDLE cycle between transactions. A cache drops its request on the edge where it sees busywait low, so the same request is never re-granted.
- D_READ and D_WRITE both high: a write is issued and the read is ignored.
- Requester drops its request mid-service: the transaction still completes to memory. The busywait output is simply 0.
- Request toggling in IDLE: only levels at the clock edge count.
- Latency, no contention, memory busy N cycles: grant edge + 1 (seen_busy) + N cycles to done.

Test Plan:
- Single icache read: I_READ=1, I_ADDRESS=0x0000010, memory busy 4 cycles, MEM_READDATA=0xA5A5... → MEM_READ high 6 cycles, GRANT=01, I_BUSYWAIT falls in done cycle, I_READDATA=0xA5A5..., GRANT→00.
- Contention after reset: I_READ and D_READ raised in the same cycle (FIRST_PRIORITY=1) → dcache served first (GRANT=10). Icache follows after exactly one IDLE cycle; I_BUSYWAIT stays 1 throughout the dcache service.
- Fairness: both requesters re-request continuously for 6 transactions → grants strictly alternate D,I,D,I,D,I.
- Write-back: D_WRITE=1, D_ADDRESS=0x00000ff, D_WRITEDATA=0x1234... → MEM_WRITE=1 with the latched address/data. The values are held unchanged even if D_WRITEDATA changes mid-service.
- Watchdog: TIMEOUT_CYCLES=8, MEM_BUSYWAIT stuck 1 → abort on cycle 8 of service, D_BUSYWAIT low that cycle, D_READDATA=0, TIMEOUT_ERR=1 until RESET pulsed low.
- Async reset mid-service: RESET low between clock edges during SERVE_I → MEM_READ, GRANT, TIMEOUT_ERR = 0 immediately. After release, state is IDLE and the first contention favours dcache.
